// File: rtl/bus_snoop_responder_if.sv
// Bus operation channel between the L2 cache (master) and the snoop responder (slave).
// Handshake: an operation transfers on a rising clk edge where bus_valid && bus_ready
// are both high; bus_op/bus_addr must be stable while bus_valid is high and unaccepted.
interface bus_snoop_responder_if #(
  parameter int i_size = 32,
  parameter int IDX_W  = 3
);
  logic              bus_valid;
  logic              bus_ready;
  logic [1:0]        bus_op;
  logic [i_size-1:0] bus_addr;
  logic              snoop_valid;
  logic [1:0]        snoop_result;
  logic              data_src;
  logic              data_beat;
  logic [IDX_W-1:0]  beat_idx;
  logic              bus_done;

  modport master (
    output bus_valid, bus_op, bus_addr,
    input  bus_ready, snoop_valid, snoop_result, data_src, data_beat, beat_idx, bus_done
  );

  modport slave (
    input  bus_valid, bus_op, bus_addr,
    output bus_ready, snoop_valid, snoop_result, data_src, data_beat, beat_idx, bus_done
  );
endinterface

// File: rtl/bus_snoop_responder.sv
// Cycle-accurate far end of the system bus: snoop response, data beats, completion
// strobe and saturating per-operation statistics for the L2 cache under test.
module bus_snoop_responder #(
  parameter int i_size    = 32,
  parameter int d_size    = 6,
  parameter int BUS_BYTES = 8,
  parameter int SNOOP_LAT = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_snoop_responder_if.slave bus,
  input  logic                 clr,
  output logic [CNT_W-1:0]     cnt_read,
  output logic [CNT_W-1:0]     cnt_write,
  output logic [CNT_W-1:0]     cnt_inval,
  output logic [CNT_W-1:0]     cnt_rwim,
  output logic [CNT_W-1:0]     cnt_hitm,
  output logic [1:0]           dbg_state
);
  localparam int BEATS = (2 ** d_size) / BUS_BYTES;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [3:0]       LAT_INIT  = 4'(SNOOP_LAT - 1);
  localparam logic [IDX_W-1:0] BEAT_LAST = IDX_W'(BEATS - 1);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INVAL = 2'd2;
  localparam logic [1:0] OP_RWIM  = 2'd3;

  localparam logic [1:0] RES_HIT   = 2'd0;
  localparam logic [1:0] RES_HITM  = 2'd1;
  localparam logic [1:0] RES_NOHIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_next;
  logic [3:0]        lat_q, lat_next;
  logic [IDX_W-1:0]  beat_q, beat_next;
  logic [1:0]        op_q, op_next;
  logic [i_size-1:0] addr_q, addr_next;
  logic              accept;

  logic             ready_q, ready_d;
  logic             snoop_valid_q, snoop_valid_d;
  logic [1:0]       snoop_result_q, snoop_result_d;
  logic             data_src_q, data_src_d;
  logic             data_beat_q, data_beat_d;
  logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
  logic             bus_done_q, bus_done_d;

  // Only the low two address bits steer the modelled peer response.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[i_size-1:2];

  // Write-backs are never snooped; a line being invalidated cannot be dirty elsewhere.
  function automatic logic [1:0] snoop_of(input logic [1:0] op, input logic [1:0] sel);
    logic [1:0] res;
    res = RES_NOHIT;
    if (op != OP_WRITE) begin
      case (sel)
        2'b00:   res = RES_HIT;
        2'b01:   res = (op == OP_INVAL) ? RES_HIT : RES_HITM;
        default: res = RES_NOHIT;
      endcase
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
  endfunction

  // State register, including the latched operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      op_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_next;
      lat_q   <= lat_next;
      beat_q  <= beat_next;
      op_q    <= op_next;
      addr_q  <= addr_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_q;
    lat_next   = lat_q;
    beat_next  = beat_q;
    op_next    = op_q;
    addr_next  = addr_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bus_valid && ready_q) begin
          accept     = 1'b1;
          op_next    = bus.bus_op;
          addr_next  = bus.bus_addr;
          lat_next   = LAT_INIT;
          state_next = SNOOP;
        end
      end
      SNOOP: begin
        if (lat_q == 4'd0) begin
          if (op_q == OP_INVAL) begin
            state_next = DONE;
          end else begin
            state_next = XFER;
            beat_next  = '0;
          end
        end else begin
          lat_next = lat_q - 4'd1;
        end
      end
      XFER: begin
        if (beat_q == BEAT_LAST) begin
          state_next = DONE;
        end else begin
          beat_next = beat_q + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: decoded from the next state so every output leaves a flop
  // in the same cycle the FSM occupies the corresponding state.
  always_comb begin
    ready_d        = (state_next == IDLE);
    snoop_valid_d  = (state_next == SNOOP) && (lat_next == 4'd0);
    snoop_result_d = snoop_valid_d ? snoop_of(op_next, addr_next[1:0]) : RES_HIT;
    data_src_d     = snoop_valid_d && (snoop_result_d == RES_HITM);
    data_beat_d    = (state_next == XFER);
    beat_idx_d     = data_beat_d ? beat_next : '0;
    bus_done_d     = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q        <= 1'b1;
      snoop_valid_q  <= 1'b0;
      snoop_result_q <= RES_HIT;
      data_src_q     <= 1'b0;
      data_beat_q    <= 1'b0;
      beat_idx_q     <= '0;
      bus_done_q     <= 1'b0;
    end else begin
      ready_q        <= ready_d;
      snoop_valid_q  <= snoop_valid_d;
      snoop_result_q <= snoop_result_d;
      data_src_q     <= data_src_d;
      data_beat_q    <= data_beat_d;
      beat_idx_q     <= beat_idx_d;
      bus_done_q     <= bus_done_d;
    end
  end

  // Statistics: clr has priority over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_read  <= '0;
      cnt_write <= '0;
      cnt_inval <= '0;
      cnt_rwim  <= '0;
      cnt_hitm  <= '0;
    end else begin
      cnt_read  <= sat_inc(cnt_read,  accept && (bus.bus_op == OP_READ));
      cnt_write <= sat_inc(cnt_write, accept && (bus.bus_op == OP_WRITE));
      cnt_inval <= sat_inc(cnt_inval, accept && (bus.bus_op == OP_INVAL));
      cnt_rwim  <= sat_inc(cnt_rwim,  accept && (bus.bus_op == OP_RWIM));
      cnt_hitm  <= sat_inc(cnt_hitm,  snoop_valid_q && (snoop_result_q == RES_HITM));
    end
  end

  assign bus.bus_ready    = ready_q;
  assign bus.snoop_valid  = snoop_valid_q;
  assign bus.snoop_result = snoop_result_q;
  assign bus.data_src     = data_src_q;
  assign bus.data_beat    = data_beat_q;
  assign bus.beat_idx     = beat_idx_q;
  assign bus.bus_done     = bus_done_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_bus_snoop_responder.sv
// Directed bench for bus_snoop_responder: per-cycle protocol checks on the default
// configuration, plus a narrow-counter instance for saturation.
module tb_bus_snoop_responder;
  localparam int L = 2;
  localparam int B = 8;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, INV = 2'd2, RWIM = 2'd3;
  localparam logic [1:0] HIT = 2'd0, HITM = 2'd1, NOHIT = 2'd2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;
  int acc_cyc = 0;
  int prev_acc = 0;

  bus_snoop_responder_if #(.i_size(32), .IDX_W(3)) mif();
  bus_snoop_responder_if #(.i_size(32), .IDX_W(1)) sif();

  logic [15:0] cnt_read, cnt_write, cnt_inval, cnt_rwim, cnt_hitm;
  logic [1:0]  dbg_state;
  logic [2:0]  s_read, s_write, s_inval, s_rwim, s_hitm;
  logic [1:0]  s_state;

  bus_snoop_responder dut (
    .clk(clk), .rst(rst), .bus(mif.slave), .clr(clr),
    .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_inval(cnt_inval),
    .cnt_rwim(cnt_rwim), .cnt_hitm(cnt_hitm), .dbg_state(dbg_state)
  );

  bus_snoop_responder #(.BUS_BYTES(32), .SNOOP_LAT(1), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .bus(sif.slave), .clr(clr),
    .cnt_read(s_read), .cnt_write(s_write), .cnt_inval(s_inval),
    .cnt_rwim(s_rwim), .cnt_hitm(s_hitm), .dbg_state(s_state)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mstat();
    return {mif.bus_ready, mif.snoop_valid, mif.snoop_result, mif.data_src,
            mif.data_beat, mif.beat_idx, mif.bus_done};
  endfunction

  function automatic logic [9:0] mexp(input bit rdy, input bit sv, input logic [1:0] res,
                                      input bit src, input bit beat, input logic [2:0] idx,
                                      input bit done);
    return {rdy, sv, res, src, beat, idx, done};
  endfunction

  task automatic check_cnts(input string tag, input int r, input int w, input int i,
                            input int m, input int h);
    check({tag, "_rd"},   32'(cnt_read),  32'(r));
    check({tag, "_wr"},   32'(cnt_write), 32'(w));
    check({tag, "_inv"},  32'(cnt_inval), 32'(i));
    check({tag, "_rwim"}, 32'(cnt_rwim),  32'(m));
    check({tag, "_hitm"}, 32'(cnt_hitm),  32'(h));
  endtask

  // Driver: one operation on the main instance, checked every cycle from C+1
  // until bus_ready returns. Called at a negedge; returns at a negedge.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] addr,
                       input logic [1:0] res, input bit keep, input bit clr_at_acc);
    int guard;
    int done_k;
    bit sv;
    bit bt;
    guard = 0;
    while (mif.bus_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, 32'(mif.bus_ready), 32'd1);
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    mif.bus_valid = 1'b1;
    mif.bus_op    = op;
    mif.bus_addr  = addr;
    clr           = clr_at_acc;
    @(negedge clk);
    clr = 1'b0;
    if (clr_at_acc) check({tag, "_clr"}, 32'(cnt_read), 32'd0);
    if (!keep) begin
      mif.bus_valid = 1'b0;
      mif.bus_op    = ~op;
      mif.bus_addr  = ~addr;
    end
    done_k = (op == INV) ? L + 1 : L + B + 1;
    for (int k = 1; k <= done_k + 1; k++) begin
      sv = (k == L);
      bt = (op != INV) && (k > L) && (k <= L + B);
      check($sformatf("%s_c%0d", tag, k), 32'(mstat()),
            32'(mexp(k > done_k, sv, sv ? res : HIT, sv && (res == HITM), bt,
                     bt ? 3'(k - L - 1) : 3'd0, k == done_k)));
      if (k <= done_k) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int t0;
    mif.bus_valid = 1'b0; mif.bus_op = 2'd0; mif.bus_addr = '0;
    sif.bus_valid = 1'b0; sif.bus_op = 2'd0; sif.bus_addr = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("in_reset", 32'(mstat()), 32'(mexp(1, 0, HIT, 0, 0, 3'd0, 0)));
    rst = 1'b0;
    @(negedge clk);
    check("idle", 32'(mstat()), 32'(mexp(1, 0, HIT, 0, 0, 3'd0, 0)));
    check("idle_state", 32'(dbg_state), 32'd0);
    check_cnts("reset", 0, 0, 0, 0, 0);

    do_op("rd40", RD, 32'h0000_0040, HIT, 0, 0);
    check_cnts("rd40", 1, 0, 0, 0, 0);
    do_op("rwim1", RWIM, 32'h1000_0001, HITM, 0, 0);
    check_cnts("rwim1", 1, 0, 0, 1, 1);
    do_op("inv1", INV, 32'h1000_0001, HIT, 0, 0);
    check_cnts("inv1", 1, 0, 1, 1, 1);
    do_op("wr2", WR, 32'h0000_0002, NOHIT, 0, 0);
    do_op("wr1", WR, 32'h0000_0001, NOHIT, 0, 0);
    check_cnts("wr", 1, 2, 1, 1, 1);

    do_op("rd3", RD, 32'h0000_0003, NOHIT, 0, 0);
    do_op("rd81", RD, 32'h0000_0081, HITM, 0, 0);
    do_op("rwim100", RWIM, 32'h0000_0100, HIT, 0, 0);
    do_op("inv2", INV, 32'h0000_0002, NOHIT, 0, 0);
    do_op("inv4", INV, 32'h0000_0004, HIT, 0, 0);
    do_op("rwim7", RWIM, 32'h0000_0007, NOHIT, 0, 0);
    check_cnts("mix", 3, 2, 3, 3, 2);

    // bus_valid held high across three READs
    do_op("b2b0", RD, 32'h0000_0040, HIT, 1, 0);
    do_op("b2b1", RD, 32'h0000_0040, HIT, 1, 0);
    check("b2b1_gap", 32'(acc_cyc - prev_acc), 32'd12);
    do_op("b2b2", RD, 32'h0000_0040, HIT, 0, 0);
    check("b2b2_gap", 32'(acc_cyc - prev_acc), 32'd12);
    check_cnts("b2b", 6, 2, 3, 3, 2);

    do_op("clr_acc", RD, 32'h0000_0040, HIT, 0, 1);
    check_cnts("clr_acc", 0, 0, 0, 0, 0);
    do_op("rd1", RD, 32'h0000_0001, HITM, 0, 0);
    check_cnts("rd1", 1, 0, 0, 0, 1);

    // Reset in cycle C+5 of a READ
    mif.bus_valid = 1'b1; mif.bus_op = RD; mif.bus_addr = 32'h0000_0040;
    @(negedge clk);
    mif.bus_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_beat", 32'(mstat()), 32'(mexp(0, 0, HIT, 0, 1, 3'd2, 0)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst", 32'(mstat()), 32'(mexp(1, 0, HIT, 0, 0, 3'd0, 0)));
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check_cnts("mid_rst", 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("mid_quiet%0d", k), 32'(mstat()), 32'(mexp(1, 0, HIT, 0, 0, 3'd0, 0)));
    end

    // Saturation on the 3-bit counter instance (2 beats, 1-cycle snoop)
    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (sif.bus_ready !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("sat_ready", 32'(sif.bus_ready), 32'd1);
      sif.bus_valid = 1'b1; sif.bus_op = RD; sif.bus_addr = 32'h0000_0040;
      t0 = cyc;
      @(negedge clk);
      sif.bus_valid = 1'b0;
      guard = 0;
      while (sif.bus_done !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("sat_done_lat%0d", i), 32'(cyc - t0), 32'd4);
      check($sformatf("sat_cnt%0d", i), 32'(s_read), (i < 7) ? 32'(i + 1) : 32'd7);
    end
    check("sat_others", 32'({s_write, s_inval, s_rwim, s_hitm}), 32'd0);
    @(negedge clk);
    check("sat_idle_state", 32'(s_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
